// File: rtl/controller_pkg.sv
// Shared controller constants: button count, code width and button index names.
// The game FSM decodes evt_code against the same button_e values.
package controller_pkg;

  localparam int unsigned N_BUTTONS = 12;
  localparam int unsigned CW        = $clog2(N_BUTTONS);

  typedef enum logic [CW-1:0] {
    BTN_UP     = 4'd0,
    BTN_DOWN   = 4'd1,
    BTN_LEFT   = 4'd2,
    BTN_RIGHT  = 4'd3,
    BTN_CENTER = 4'd4,
    BTN_ERASE  = 4'd5,
    BTN_UNDO   = 4'd6,
    BTN_HINT   = 4'd7,
    BTN_NEW    = 4'd8,
    BTN_CHECK  = 4'd9,
    BTN_MODE   = 4'd10,
    BTN_START  = 4'd11
  } button_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fallthrough FIFO with wrapping pointers and a separate occupancy counter.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign pop_en  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_en = push && (!full || pop_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_en) rd_ptr <= rd_ptr + AW'(1);
      if (push_en && !pop_en)      level <= level + LW'(1);
      else if (!push_en && pop_en) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/button_event_queue.sv
// Serializes simultaneous button pulses into codes via a pending register and
// lowest-index-first grant, buffering them in a FWFT FIFO for the game FSM.
module button_event_queue
  import controller_pkg::*;
#(
  parameter int unsigned N_BUTTONS = controller_pkg::N_BUTTONS,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_BUTTONS-1:0]         pulse_in,
  input  logic                         clear,
  output logic                         evt_valid,
  output logic [$clog2(N_BUTTONS)-1:0] evt_code,
  input  logic                         evt_ready,
  output logic                         evt_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned CODE_W = $clog2(N_BUTTONS);

  logic [N_BUTTONS-1:0] pend;
  logic [N_BUTTONS-1:0] grant;
  logic [CODE_W-1:0]    grant_idx;
  logic                 found;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;

  assign evt_valid = !empty;
  assign pop       = evt_valid && evt_ready;
  assign push      = (pend != '0) && (!full || pop);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N_BUTTONS; i++) begin
      if (pend[i] && !found) begin
        found     = 1'b1;
        grant_idx = CODE_W'(i);
        if (push) grant[i] = 1'b1;
      end
    end
  end

  // A repeat pulse on a bit that stays pending is merged away and flagged;
  // a pulse coinciding with that bit's grant re-arms it instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend         <= '0;
      evt_overflow <= 1'b0;
    end else if (clear) begin
      pend         <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pend <= (pend & ~grant) | pulse_in;
      if ((pulse_in & pend & ~grant) != '0) evt_overflow <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (grant_idx),
    .dout  (evt_code),
    .empty (empty),
    .full  (full),
    .level (level)
  );

endmodule
